// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a CPU port (0) and a DMA port (1) onto one shared single-cycle dmem bus.
// Ports: clk, rst (sync, active-high); per port k: req/lock/we/a/wd in, gnt/rvalid/rd out;
//        shared bus: bus_we/bus_a/bus_wd out, bus_rd in (combinational from bus_a); owner = FSM state.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          bus_we,
  output logic [AW-1:0] bus_a,
  output logic [DW-1:0] bus_wd,
  input  logic [DW-1:0] bus_rd,
  output logic [1:0]    owner
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK - 1);
  state_t state, state_nx;
  logic [7:0] lock_cnt, lock_cnt_nx;
  logic last, last_nx;
  logic hold, pick1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lock_cnt <= '0;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      lock_cnt <= lock_cnt_nx;
      last <= last_nx;
    end
  end
  // last is the most recently granted port; the current cycle's grant counts, so the
  // arbitration at the end of a grant cycle already sees that port as lowest priority.
  always_comb begin
    last_nx = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
`ifdef ARB_ROUND_ROBIN_EN
    pick1 = req1 & (~req0 | ~last_nx);
`else
    pick1 = req1 & ~req0;
`endif
    hold = ((state == OWN0) ? req0 & lock0 : (state == OWN1) ? req1 & lock1 : 1'b0) & (lock_cnt < LOCK_LIM);
    state_nx = hold ? state : pick1 ? OWN1 : (req0 | req1) ? OWN0 : IDLE;
    lock_cnt_nx = hold ? lock_cnt + 8'd1 : 8'd0;
  end
  always_comb begin
    gnt0 = (state == OWN0) & req0;
    gnt1 = (state == OWN1) & req1;
    bus_we = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
    bus_a = gnt0 ? a0 : gnt1 ? a1 : '0;
    bus_wd = gnt0 ? wd0 : gnt1 ? wd1 : '0;
    owner = state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) rd0 <= bus_rd;
      if (gnt1 & ~we1) rd1 <= bus_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with literal expectations plus a per-cycle reference model compare.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, ML = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, bus_we;
  logic [DW-1:0] rd0, rd1, bus_wd, bus_rd;
  logic [AW-1:0] bus_a;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  logic started = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rd0(rd0), .rd1(rd1),
    .bus_we(bus_we), .bus_a(bus_a), .bus_wd(bus_wd), .bus_rd(bus_rd), .owner(owner)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  assign bus_rd = mem(bus_a);
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask
  // Reference model: who owns the bus, length of the current locked run, last granted port,
  // and the read return scheduled for the next cycle.
  int m_own = 0, m_run = 0, m_last = 1, recent, win;
  logic m_rv0 = 0, m_rv1 = 0, e_g0, e_g1, e_we, stay;
  logic [31:0] m_rd0 = 0, m_rd1 = 0, e_a, e_wd;
  always_comb begin
    e_g0 = (m_own == 1) && req0;
    e_g1 = (m_own == 2) && req1;
    e_we = e_g0 ? we0 : e_g1 ? we1 : 1'b0;
    e_a = e_g0 ? a0 : e_g1 ? a1 : 32'h0;
    e_wd = e_g0 ? wd0 : e_g1 ? wd1 : 32'h0;
    recent = e_g0 ? 0 : e_g1 ? 1 : m_last;
    stay = ((m_own == 1 && req0 && lock0) || (m_own == 2 && req1 && lock1)) && (m_run + 1 < ML);
`ifdef ARB_ROUND_ROBIN_EN
    win = (req0 && req1) ? ((recent == 0) ? 2 : 1) : req0 ? 1 : req1 ? 2 : 0;
`else
    win = req0 ? 1 : req1 ? 2 : 0;
`endif
  end
  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0;
      m_run <= 0;
      m_last <= 1;
      m_rv0 <= 0;
      m_rv1 <= 0;
      m_rd0 <= 0;
      m_rd1 <= 0;
    end else begin
      m_rv0 <= e_g0 && !we0;
      m_rv1 <= e_g1 && !we1;
      if (e_g0 && !we0) m_rd0 <= mem(a0);
      if (e_g1 && !we1) m_rd1 <= mem(a1);
      m_last <= recent;
      m_run <= stay ? m_run + 1 : 0;
      if (!stay) m_own <= win;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("model_ctrl", {gnt0, gnt1, owner, bus_we, rvalid0, rvalid1},
          {e_g0, e_g1, 2'(m_own), e_we, m_rv0, m_rv1});
      chk("model_bus_a", bus_a, e_a);
      chk("model_bus_wd", bus_wd, e_wd);
      chk("model_rd0", rd0, m_rd0);
      chk("model_rd1", rd1, m_rd1);
      chk("no_double_gnt", gnt0 & gnt1, 0);
      chk("we_without_gnt", bus_we & ~(gnt0 | gnt1), 0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    {req0, req1, lock0, lock1, we0, we1} = '0;
    tick();
    tick();
    rst = 0;
  endtask
  logic [5:0] vec [16] = '{6'b100000, 6'b110000, 6'b111000, 6'b111000, 6'b110100, 6'b010100,
                           6'b010101, 6'b000000, 6'b101010, 6'b100010, 6'b011100, 6'b111100,
                           6'b111111, 6'b110011, 6'b010000, 6'b000000};
  initial begin
    do_reset();
    started = 1;
    settle();
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_bus_a", bus_a, 0);
    // single read from IDLE: grant next cycle, data the cycle after
    req0 = 1; we0 = 0; a0 = 32'h10;
    settle();
    chk("A_idle_no_gnt", gnt0, 0);
    tick(); settle();
    chk("A_gnt0", gnt0, 1);
    chk("A_bus_a", bus_a, 32'h10);
    chk("A_owner", owner, 2'b01);
    tick(); req0 = 0; settle();
    chk("A_rvalid0", rvalid0, 1);
    chk("A_rd0", rd0, 32'hDEADBEEF);
    chk("A_no_gnt_without_req", gnt0, 0);
    tick(); settle();
    chk("A_back_idle", owner, 2'b00);
    chk("A_rvalid0_low", rvalid0, 0);
    chk("A_rd0_hold", rd0, 32'hDEADBEEF);
    // continuous contention without lock
    do_reset();
    req0 = 1; req1 = 1; a0 = 32'h100; a1 = 32'h200;
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
`ifdef ARB_ROUND_ROBIN_EN
      chk("B_rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      chk("B_rr_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
`else
      chk("B_fix_gnt0", gnt0, 1);
      chk("B_fix_gnt1", gnt1, 0);
`endif
    end
    tick(); settle();
    chk("B_rd_contended", rd0, 32'h0100FEFF);
    // locked DMA holds for exactly MAX_LOCK grants, then CPU gets in
    do_reset();
    req1 = 1; lock1 = 1; a1 = 32'h300;
    tick(); req0 = 1; a0 = 32'h104;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("C_locked_gnt1", gnt1, 1);
      chk("C_locked_gnt0", gnt0, 0);
      tick();
    end
    settle();
    chk("C_release_gnt0", gnt0, 1);
    chk("C_release_gnt1", gnt1, 0);
    // DMA write: bus strobe for one cycle, no read return
    do_reset();
    req1 = 1; we1 = 1; a1 = 32'h24; wd1 = 32'h12345678;
    settle();
    chk("D_idle_we", bus_we, 0);
    tick(); settle();
    chk("D_gnt1", gnt1, 1);
    chk("D_bus_we", bus_we, 1);
    chk("D_bus_a", bus_a, 32'h24);
    chk("D_bus_wd", bus_wd, 32'h12345678);
    tick(); req1 = 0; we1 = 0; settle();
    chk("D_rvalid1", rvalid1, 0);
    chk("D_bus_idle", {31'b0, bus_we} | bus_a | bus_wd, 0);
    // reset during a locked read discards the return and clears rd
    do_reset();
    req0 = 1; lock0 = 1; a0 = 32'h10;
    tick(); settle();
    chk("E_gnt0", gnt0, 1);
    tick(); settle();
    chk("E_rd0_before", rd0, 32'hDEADBEEF);
    rst = 1;
    tick(); settle();
    chk("E_rvalid0", rvalid0, 0);
    chk("E_rd0", rd0, 0);
    chk("E_owner", owner, 0);
    chk("E_gnt0_after", gnt0, 0);
    rst = 0; req0 = 0; lock0 = 0;
    // mixed vectors checked by the model only
    for (int i = 0; i < 16; i++) begin
      tick();
      {req0, req1, lock0, lock1, we0, we1} = vec[i];
      a0 = 32'h400 + 32'(i * 4);
      a1 = 32'h800 + 32'(i * 8);
      wd0 = 32'hA000 + 32'(i);
      wd1 = 32'hB000 + 32'(i);
    end
    tick();
    {req0, req1, lock0, lock1, we0, we1} = '0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter MAX_LOCK, default 8, max consecutive locked grants to one port (range 1..255).
REQ-004 SHALL have one clock; reset is synchronous and active-high (clk, rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req0, req1  input  1 each  access request, port 0 = CPU, port 1 = DMA.
REQ-008 lock0, lock1  input  1 each  keep ownership for the next access.
REQ-009 we0, we1  input  1 each  write enable of the requested access.
REQ-010 a0, a1  input  AW each  access address, held stable while req high.
REQ-011 wd0, wd1  input  DW each  write data, held stable while req high.
REQ-012 gnt0, gnt1  output  1 each  access issued to the bus this cycle.
REQ-013 rvalid0, rvalid1  output  1 each  read data valid for the previous grant.
REQ-014 rd0, rd1  output  DW each  read data returned to the port.
REQ-015 bus_we  output  1  write strobe to the shared dmem/peripheral bus.
REQ-016 bus_a  output  AW  shared bus address.
REQ-017 bus_wd  output  DW  shared bus write data.
REQ-018 bus_rd  input  DW  shared bus read data, combinational from bus_a.
REQ-019 owner  output  2  state: 00 IDLE, 01 OWN0, 10 OWN1.

Function
REQ-020 SHALL implement FSM states IDLE, OWN0, OWN1; owner output encodes current state.
REQ-021 IDLE: any req sampled at edge moves to OWNk for the winner; no req stays IDLE; no grant is issued in IDLE.
REQ-022 OWNk: gnt_k = req_k combinationally; the other gnt SHALL be 0.
REQ-023 While gnt_k = 1: bus_a = a_k, bus_wd = wd_k, bus_we = we_k; otherwise bus_we = 0, bus_a = 0, bus_wd = 0.
REQ-024 Request-to-grant latency SHALL be exactly 1 cycle from IDLE; throughput SHALL be one access per cycle.
REQ-025 On each grant cycle with we_k = 0, bus_rd SHALL be registered; rvalid_k = 1 and rd_k = that data exactly on the next cycle; write grants SHALL NOT raise rvalid.
REQ-026 rd_k SHALL hold its last value when rvalid_k = 0.
REQ-027 At the end of an OWNk cycle: if req_k & lock_k & lock_cnt < MAX_LOCK-1, stay OWNk and increment lock_cnt; else re-arbitrate among current reqs (winner -> OWNj with no idle bubble, none -> IDLE) and clear lock_cnt.
REQ-028 OWNk with req_k = 0: no grant; re-arbitrate at the edge per REQ-027.
REQ-029 lock_cnt SHALL saturate-release: the MAX_LOCK-th consecutive locked grant forces re-arbitration; with MAX_LOCK = 1 lock is ignored.
REQ-030 Arbitration policy SHALL be selected per REQ-034/REQ-035; a lone requester always wins.
REQ-031 Simultaneous req0 and req1 in IDLE SHALL resolve in one cycle with no double grant; gnt0 & gnt1 SHALL never both be 1.

Reset
REQ-032 rst SHALL force IDLE, lock_cnt = 0, RR pointer = port 0 priority, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rd0 = rd1 = 0, bus_we = 0, bus_a = 0, bus_wd = 0, owner = 00.
REQ-033 rst asserted mid-operation SHALL discard any pending read return (no rvalid the following cycle) and abort a lock.

Configuration
REQ-034 With macro ARB_ROUND_ROBIN_EN defined: round-robin; the port granted most recently has lowest priority on the next contended arbitration; pointer updates only on a grant.
REQ-035 Without ARB_ROUND_ROBIN_EN: fixed priority, port 0 always wins contention; lock semantics unchanged.

Verification
REQ-036 Reset, then req0 = 1, we0 = 0, a0 = 0x10, bus_rd = 0xDEADBEEF -> gnt0 on cycle 2, rvalid0 = 1 with rd0 = 0xDEADBEEF on cycle 3.
REQ-037 req0 = req1 = 1 continuously, no lock, RR build -> grants alternate 0,1,0,1; fixed build -> gnt0 every cycle, gnt1 never.
REQ-038 MAX_LOCK = 4, req1 + lock1 held, req0 = 1 -> exactly 4 consecutive gnt1, then gnt0 the next cycle.
REQ-039 Write: req1 = 1, we1 = 1, a1 = 0x24, wd1 = 0x12345678 -> bus_we = 1, bus_a = 0x24, bus_wd = 0x12345678 for one cycle, rvalid1 stays 0.
REQ-040 Read granted, rst asserted next cycle -> rvalid0 = 0, rd0 = 0, owner = 00 after the edge.
REQ-041 Assertions across all tests: never gnt0 & gnt1; bus_we = 0 whenever no grant.
